// File: rtl/mips_pkg.sv
// Shared constants for the MIPS pipeline: reset values and opcode encodings.
package mips_pkg;
  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;
  localparam int          CNT_W_DEFAULT     = 16;

  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_ADDI = 6'b001000;
endpackage

// File: rtl/fetch_stage_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; stops at all-ones and never wraps.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);
  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // next count: clear wins, then increment unless already saturated
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = {W{1'b0}};
    end else if (inc && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // count register
  always_ff @(posedge clk) begin
    cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;
endmodule

// File: rtl/fetch_stage_ctrl.sv
// IF stage: PC register, next-PC redirect mux, IF/ID pipeline register and
// stall/flush performance counters.
module fetch_stage_ctrl
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT,
  parameter int          CNT_W     = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             PC_WriteEn,
  input  logic             IFID_WriteEn,
  input  logic             IF_flush,
  input  logic             jump,
  input  logic [31:0]      jump_target,
  input  logic             branch_taken,
  input  logic [31:0]      branch_target,
  input  logic             jr,
  input  logic [31:0]      jr_target,
  input  logic [31:0]      imem_instr,
  output logic [31:0]      imem_addr,
  output logic [31:0]      ID_Instr,
  output logic [31:0]      ID_PC4,
  output logic             ID_valid,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;
  logic [31:0] pc4_s;
  logic [31:0] next_pc_s;
  logic        stall_inc_s;
  logic        flush_inc_s;

  assign pc4_s = pc_q + 32'd4;

  // redirect mux, priority jr > jump > branch
  always_comb begin
    next_pc_s = pc4_s;
    if (jr) begin
      next_pc_s = jr_target;
    end else if (jump) begin
      next_pc_s = jump_target;
    end else if (branch_taken) begin
      next_pc_s = branch_target;
    end else begin
      next_pc_s = pc4_s;
    end
  end

  // PC and IF/ID next state; a stall freezes the PC and defers any flush
  always_comb begin
    pc_d        = pc_q;
    instr_d     = instr_q;
    pc4_d       = pc4_q;
    valid_d     = valid_q;
    stall_inc_s = 1'b0;
    flush_inc_s = 1'b0;
    if (!PC_WriteEn) begin
      stall_inc_s = 1'b1;
      if (IFID_WriteEn) begin
        instr_d = imem_instr;
        pc4_d   = pc4_s;
        valid_d = 1'b1;
      end else begin
        instr_d = instr_q;
      end
    end else begin
      pc_d = next_pc_s;
      if (IF_flush) begin
        instr_d     = NOP_INSTR;
        pc4_d       = pc4_s;
        valid_d     = 1'b0;
        flush_inc_s = 1'b1;
      end else if (IFID_WriteEn) begin
        instr_d = imem_instr;
        pc4_d   = pc4_s;
        valid_d = 1'b1;
      end else begin
        instr_d = instr_q;
      end
    end
  end

  // pipeline registers
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= RESET_PC;
      instr_q <= NOP_INSTR;
      pc4_q   <= 32'h0000_0000;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .clr (reset),
    .inc (stall_inc_s),
    .cnt (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk (clk),
    .clr (reset),
    .inc (flush_inc_s),
    .cnt (flush_cnt)
  );

  assign imem_addr = pc_q;
  assign ID_Instr  = instr_q;
  assign ID_PC4    = pc4_q;
  assign ID_valid  = valid_q;
endmodule

// File: tb/tb_fetch_stage_ctrl.sv
// Directed bench for fetch_stage_ctrl: a behavioural model checked every cycle,
// plus literal expectations taken from hand-worked scenarios.
module tb_fetch_stage_ctrl;
  logic        clk;
  logic        reset;
  logic        PC_WriteEn, IFID_WriteEn, IF_flush;
  logic        jump, branch_taken, jr;
  logic [31:0] jump_target, branch_target, jr_target;
  logic [31:0] imem_instr, imem_instr4;
  logic [31:0] imem_addr, ID_Instr, ID_PC4;
  logic        ID_valid;
  logic [15:0] stall_cnt, flush_cnt;
  logic [31:0] imem_addr4, ID_Instr4, ID_PC44;
  logic        ID_valid4;
  logic [3:0]  stall_cnt4, flush_cnt4;

  int n_pass  = 0;
  int n_total = 0;
  bit chk_en  = 1'b0;

  // model state
  logic [31:0] m_pc, m_instr, m_pc4;
  logic        m_valid;
  int          m_stall, m_flush, m_stall4, m_flush4;

  function automatic logic [31:0] imem_f(input logic [31:0] a);
    return {a[15:0] ^ 16'hC0DE, a[31:16] ^ 16'hBEEF} ^ {a[7:0], 24'h000000};
  endfunction

  assign imem_instr  = imem_f(imem_addr);
  assign imem_instr4 = imem_f(imem_addr4);

  fetch_stage_ctrl dut (
    .clk(clk), .reset(reset), .PC_WriteEn(PC_WriteEn), .IFID_WriteEn(IFID_WriteEn),
    .IF_flush(IF_flush), .jump(jump), .jump_target(jump_target),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jr(jr), .jr_target(jr_target), .imem_instr(imem_instr),
    .imem_addr(imem_addr), .ID_Instr(ID_Instr), .ID_PC4(ID_PC4),
    .ID_valid(ID_valid), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  fetch_stage_ctrl #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .PC_WriteEn(PC_WriteEn), .IFID_WriteEn(IFID_WriteEn),
    .IF_flush(IF_flush), .jump(jump), .jump_target(jump_target),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jr(jr), .jr_target(jr_target), .imem_instr(imem_instr4),
    .imem_addr(imem_addr4), .ID_Instr(ID_Instr4), .ID_PC4(ID_PC44),
    .ID_valid(ID_valid4), .stall_cnt(stall_cnt4), .flush_cnt(flush_cnt4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%h required=%h", name, act, exp);
  endtask

  // per-cycle compare against the model
  always @(negedge clk) begin
    if (chk_en) begin
      check("m_pc",     imem_addr, m_pc);
      check("m_instr",  ID_Instr,  m_instr);
      check("m_pc4",    ID_PC4,    m_pc4);
      check("m_valid",  {31'd0, ID_valid}, {31'd0, m_valid});
      check("m_stall",  {16'd0, stall_cnt}, m_stall);
      check("m_flush",  {16'd0, flush_cnt}, m_flush);
      check("m_pc_w4",  imem_addr4, m_pc);
      check("m_stall4", {28'd0, stall_cnt4}, m_stall4);
      check("m_flush4", {28'd0, flush_cnt4}, m_flush4);
    end
  end

  task automatic step(input logic rst, input logic pcw, input logic ifw, input logic fl,
                      input logic j, input logic [31:0] jt, input logic br,
                      input logic [31:0] bt, input logic jrr, input logic [31:0] jrt);
    logic [31:0] n_pc, n_instr, n_pc4, seq;
    logic        n_valid;
    int          n_stall, n_flush, n_stall4, n_flush4;
    reset = rst; PC_WriteEn = pcw; IFID_WriteEn = ifw; IF_flush = fl;
    jump = j; jump_target = jt; branch_taken = br; branch_target = bt;
    jr = jrr; jr_target = jrt;
    seq = m_pc + 32'd4;
    n_pc = m_pc; n_instr = m_instr; n_pc4 = m_pc4; n_valid = m_valid;
    n_stall = m_stall; n_flush = m_flush; n_stall4 = m_stall4; n_flush4 = m_flush4;
    if (rst) begin
      n_pc = 32'd0; n_instr = 32'd0; n_pc4 = 32'd0; n_valid = 1'b0;
      n_stall = 0; n_flush = 0; n_stall4 = 0; n_flush4 = 0;
    end else if (!pcw) begin
      if (n_stall < 65535) n_stall++;
      if (n_stall4 < 15) n_stall4++;
      if (ifw) begin n_instr = imem_f(m_pc); n_pc4 = seq; n_valid = 1'b1; end
    end else begin
      n_pc = jrr ? jrt : (j ? jt : (br ? bt : seq));
      if (fl) begin
        n_instr = 32'd0; n_pc4 = seq; n_valid = 1'b0;
        if (n_flush < 65535) n_flush++;
        if (n_flush4 < 15) n_flush4++;
      end else if (ifw) begin
        n_instr = imem_f(m_pc); n_pc4 = seq; n_valid = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    m_pc = n_pc; m_instr = n_instr; m_pc4 = n_pc4; m_valid = n_valid;
    m_stall = n_stall; m_flush = n_flush; m_stall4 = n_stall4; m_flush4 = n_flush4;
  endtask

  task automatic idle();
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
  endtask

  task automatic stall();
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
  endtask

  initial begin
    reset = 1'b1; PC_WriteEn = 1'b1; IFID_WriteEn = 1'b1; IF_flush = 1'b0;
    jump = 1'b0; branch_taken = 1'b0; jr = 1'b0;
    jump_target = 32'd0; branch_target = 32'd0; jr_target = 32'd0;
    m_pc = 32'd0; m_instr = 32'd0; m_pc4 = 32'd0; m_valid = 1'b0;
    m_stall = 0; m_flush = 0; m_stall4 = 0; m_flush4 = 0;

    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
    chk_en = 1'b1;
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
    check("rst_addr",  imem_addr, 32'h0);
    check("rst_valid", {31'd0, ID_valid}, 32'd0);
    check("rst_instr", ID_Instr, 32'h0);
    check("rst_stall", {16'd0, stall_cnt}, 32'd0);
    check("rst_flush", {16'd0, flush_cnt}, 32'd0);

    for (int i = 1; i <= 3; i++) begin
      idle();
      check("seq_addr",  imem_addr, 32'(4 * i));
      check("seq_pc4",   ID_PC4,    32'(4 * i));
      check("seq_valid", {31'd0, ID_valid}, 32'd1);
    end
    idle();
    check("pc_10", imem_addr, 32'h10);

    stall();
    check("stall_pc",    imem_addr, 32'h10);
    check("stall_instr", ID_Instr, imem_f(32'hC));
    check("stall_cnt",   {16'd0, stall_cnt}, 32'd1);
    idle();
    check("resume_pc", imem_addr, 32'h14);

    idle(); idle(); idle();
    check("pc_20", imem_addr, 32'h20);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h40, 1'b0, 32'd0, 1'b0, 32'd0);
    check("jmp_addr",  imem_addr, 32'h40);
    check("jmp_instr", ID_Instr, 32'h0);
    check("jmp_valid", {31'd0, ID_valid}, 32'd0);
    check("jmp_flush", {16'd0, flush_cnt}, 32'd1);

    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 1'b1, 32'h60, 1'b1, 32'h80);
    check("jr_prio", imem_addr, 32'h80);

    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 1'b1, 32'h60, 1'b0, 32'd0);
    check("sr_pc",    imem_addr, 32'h80);
    check("sr_instr", ID_Instr, imem_f(32'h40));
    check("sr_flush", {16'd0, flush_cnt}, 32'd1);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'd0, 1'b1, 32'h60, 1'b0, 32'd0);
    check("br_pc",    imem_addr, 32'h60);
    check("br_flush", {16'd0, flush_cnt}, 32'd2);
    check("br_valid", {31'd0, ID_valid}, 32'd0);

    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'd0, 1'b0, 32'd0);
    check("top_pc", imem_addr, 32'hFFFF_FFFC);
    idle();
    check("wrap_pc",  imem_addr, 32'h0);
    check("wrap_pc4", ID_PC4, 32'h0);

    for (int i = 0; i < 16; i++) stall();
    check("sat4",  {28'd0, stall_cnt4}, 32'd15);
    check("cnt16", {16'd0, stall_cnt}, 32'd18);

    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
    check("mrst_addr",  imem_addr, 32'h0);
    check("mrst_instr", ID_Instr, 32'h0);
    check("mrst_pc4",   ID_PC4, 32'h0);
    check("mrst_valid", {31'd0, ID_valid}, 32'd0);
    check("mrst_stall", {16'd0, stall_cnt}, 32'd0);
    check("mrst_flush", {16'd0, flush_cnt}, 32'd0);
    idle();
    @(negedge clk);
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/fetch_stage_ctrl.md
Name: fetch_stage_ctrl

Overview:
- Owns the PC register and the IF/ID pipeline register.
- Consumes the hazard and discard controls (PC_WriteEn, IFID_WriteEn, IF_flush) and the ID-stage redirects (jump, branch, jr).
- Presents the fetched instruction to ID with a valid bit.
- Counts stall and flush cycles for performance debug.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0000, instruction word inserted into IF/ID on flush or reset.
- CNT_W, 16, width of the saturating stall and flush counters.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- PC_WriteEn  input  1  0 = hold PC (load-use stall).
- IFID_WriteEn  input  1  0 = hold IF/ID contents.
- IF_flush  input  1  replace the fetched instruction with NOP_INSTR.
- jump  input  1  ID-stage j/jal redirect.
- jump_target  input  32  target for jump.
- branch_taken  input  1  ID-stage taken branch (bne/beq).
- branch_target  input  32  target for branch.
- jr  input  1  ID-stage jr redirect.
- jr_target  input  32  register target for jr.
- imem_instr  input  32  instruction at imem_addr (combinational imem).
- imem_addr  output  32  current PC.
- ID_Instr  output  32  registered instruction.
- ID_PC4  output  32  registered PC+4 of ID_Instr.
- ID_valid  output  1  0 = bubble in ID.
- stall_cnt  output  CNT_W  cycles with PC_WriteEn=0.
- flush_cnt  output  CNT_W  cycles in which a flush took effect.

Behaviour:
- Reset (synchronous, on a clk edge with reset=1), overriding all other inputs:
  - PC=RESET_PC.
  - ID_Instr=NOP_INSTR, ID_PC4=0, ID_valid=0.
  - stall_cnt=0, flush_cnt=0.
- imem_addr = PC, combinational from the register.
- pc4 = PC+32'd4, modulo 2^32 (0xFFFF_FFFC wraps to 0).
- Redirect priority: jr > jump > branch_taken.
  - redirect = jr | jump | branch_taken.
  - next_pc = selected target if redirect, else pc4.
  - Targets are used as-is, with no alignment check.
- Per edge, when not in reset:
  - Case 1, PC_WriteEn=0 (stall):
    - PC holds.
    - Redirects are ignored: the operand of a branch in ID is not ready yet.
    - If IFID_WriteEn=0, IF/ID holds, and IF_flush is ignored.
    - If IFID_WriteEn=1, IF/ID loads normally (tolerated, not expected).
    - stall_cnt increments, saturating at all-ones.
  - Case 2, PC_WriteEn=1: PC=next_pc.
    - If IF_flush=1: ID_Instr=NOP_INSTR, ID_valid=0, ID_PC4=pc4; flush_cnt increments, saturating.
    - Else if IFID_WriteEn=1: ID_Instr=imem_instr, ID_PC4=pc4, ID_valid=1.
    - Else: IF/ID holds.
- Flush while the stall is active: flush takes effect only on the first cycle PC_WriteEn returns to 1, if it is still asserted then.
- Latency:
  - One cycle from fetch to ID.
  - A redirect in cycle N gives imem_addr=target in cycle N+1.
  - The wrong-path instruction fetched in cycle N is squashed only if the discard logic asserts IF_flush in N.
- No internal FSM beyond the registers. The counters are the only state other than the pipeline state.
- Counters never wrap. They clear only on reset.

Decomposition:
- Shared package (mips_pkg):
  - NOP_INSTR value.
  - RESET_PC default.
  - opcode constants used elsewhere (OP_ORI 6'b001101, OP_LW 6'b100011, OP_ADDI 6'b001000).
- One natural sub-module: sat_counter (CNT_W-wide saturating incrementer with synchronous clear), instantiated twice.
- The next-PC mux stays inline.

Test Plan:
- Reset → imem_addr=0, ID_valid=0, ID_Instr=0, both counters 0. After release, 3 cycles with no hazards give imem_addr 4, 8, 12 and ID_PC4 4, 8, 12, ID_valid=1.
- Load-use stall: PC_WriteEn=0 and IFID_WriteEn=0 for 1 cycle at PC=0x10 → PC stays 0x10, ID_Instr unchanged, stall_cnt=1. The next cycle resumes at 0x14.
- jump=1, jump_target=0x40, IF_flush=1 at PC=0x20 → next imem_addr=0x40, ID_Instr=NOP, ID_valid=0, flush_cnt=1.
- jr=1 (jr_target=0x80) and branch_taken=1 (branch_target=0x60) together → imem_addr=0x80.
- Stall plus redirect: PC_WriteEn=0, IFID_WriteEn=0, branch_taken=1, IF_flush=1 → PC and IF/ID hold, flush_cnt unchanged. Next cycle with no stall and the branch still taken → PC=branch_target, flush applied.
- Edge cases:
  - PC=0xFFFF_FFFC with no redirect → PC=0 (wrap).
  - stall_cnt preset near max by 2^CNT_W stall cycles (CNT_W=4 override) → saturates at 15.
  - reset asserted mid-stall → all outputs at reset values on the next edge.
